// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: register enables/flushes, PC enable, halt drain.
// Latency: enables/flushes/pc_en are combinational from state and inputs; halted and stall_count are registered.
// Backpressure: a pending data access freezes the whole pipe, and fetch misses or load-use hazards insert bubbles.
module pipeline_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_EX_MEM,
   input  logic             dWEN_EX_MEM,
   input  logic             dREN_ID_EX,
   input  logic [REG_W-1:0] Rt_ID_EX,
   input  logic [REG_W-1:0] Rs_IF_ID,
   input  logic [REG_W-1:0] Rt_IF_ID,
   input  logic             branch_taken_EX,
   input  logic             jump_ID,
   input  logic             halt_ID,
   input  logic             halt_MEM_WB,
   output logic             pc_en,
   output logic             enable_IF_ID,
   output logic             flush_IF_ID,
   output logic             enable_ID_EX,
   output logic             flush_ID_EX,
   output logic             enable_EX_MEM,
   output logic             flush_EX_MEM,
   output logic             enable_MEM_WB,
   output logic             flush_MEM_WB,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             dstall;
   logic             luse;

   // Memory stall: a load/store in MEM that has not completed yet.
   assign dstall = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
   // Load-use: a load in EX whose non-zero destination feeds the instruction in ID.
   assign luse   = dREN_ID_EX & (Rt_ID_EX != '0) &
                   ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

   // Prioritised hazard resolution and next-state selection.
   always_comb begin
      state_d       = state_q;
      pc_en         = 1'b1;
      enable_IF_ID  = 1'b1;
      flush_IF_ID   = 1'b0;
      enable_ID_EX  = 1'b1;
      flush_ID_EX   = 1'b0;
      enable_EX_MEM = 1'b1;
      flush_EX_MEM  = 1'b0;
      enable_MEM_WB = 1'b1;
      flush_MEM_WB  = 1'b0;

      if (state_q == HALTED) begin
         pc_en         = 1'b0;
         enable_IF_ID  = 1'b0;
         enable_ID_EX  = 1'b0;
         enable_EX_MEM = 1'b0;
         enable_MEM_WB = 1'b0;
      end else begin
         if (dstall) begin
            // Freeze everything; any state change waits for the access to finish.
            pc_en         = 1'b0;
            enable_IF_ID  = 1'b0;
            enable_ID_EX  = 1'b0;
            enable_EX_MEM = 1'b0;
            enable_MEM_WB = 1'b0;
         end else if (branch_taken_EX) begin
            // Redirect: kill the two younger instructions, even a fetch still in flight.
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            if (state_q == DRAIN) begin
               state_d = RUN;  // the halt in flight was on the wrong path
            end
         end else if (state_q == DRAIN) begin
            // Stop fetching and feed bubbles behind the HALT.
            pc_en       = 1'b0;
            flush_IF_ID = 1'b1;
         end else if (luse || !ihit) begin
            pc_en        = 1'b0;
            enable_IF_ID = 1'b0;
            flush_ID_EX  = 1'b1;
         end else if (jump_ID) begin
            flush_IF_ID = 1'b1;
         end

         // Enter drain only when the HALT actually moves into ID/EX this cycle.
         if (state_q == RUN && halt_ID && !dstall && enable_ID_EX && !flush_ID_EX) begin
            state_d = DRAIN;
         end
         // HALT reaching MEM/WB wins over a redirect in the same cycle.
         if (halt_MEM_WB && !dstall) begin
            state_d = HALTED;
         end
      end
   end

   // Stall-cycle counter, saturating at all-ones.
   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_en && state_q != HALTED && stall_count_q != '1) begin
         stall_count_d = stall_count_q + CNT_W'(1);
      end
   end

   // State and counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= RUN;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign halted      = (state_q == HALTED);
   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Latency: checks combinational controls mid-cycle, registered outputs just after the edge.
// Backpressure: exercises memory stalls, load-use, fetch misses, redirects and the halt drain.
module tb_pipeline_ctrl;

   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   // Control vector order: pc_en, en/fl IF_ID, en/fl ID_EX, en/fl EX_MEM, en/fl MEM_WB
   localparam logic [8:0] C_NORM   = 9'b1_10_10_10_10;
   localparam logic [8:0] C_FROZEN = 9'b0_00_00_00_00;
   localparam logic [8:0] C_BUBBLE = 9'b0_00_11_10_10;
   localparam logic [8:0] C_BRANCH = 9'b1_11_11_10_10;
   localparam logic [8:0] C_DRAIN  = 9'b0_11_10_10_10;
   localparam logic [8:0] C_JUMP   = 9'b1_11_10_10_10;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX;
   logic [REG_W-1:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
   logic             branch_taken_EX, jump_ID, halt_ID, halt_MEM_WB;
   logic             pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
   logic             enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB;
   logic             halted;
   logic [CNT_W-1:0] stall_count;
   logic [8:0]       ctl;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .dREN_ID_EX(dREN_ID_EX),
      .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
      .branch_taken_EX(branch_taken_EX), .jump_ID(jump_ID), .halt_ID(halt_ID),
      .halt_MEM_WB(halt_MEM_WB), .pc_en(pc_en),
      .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
      .enable_ID_EX(enable_ID_EX), .flush_ID_EX(flush_ID_EX),
      .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
      .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
      .halted(halted), .stall_count(stall_count)
   );

   assign ctl = {pc_en, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
                 enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b0; dREN_EX_MEM = 1'b0; dWEN_EX_MEM = 1'b0;
      dREN_ID_EX = 1'b0; Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0;
      branch_taken_EX = 1'b0; jump_ID = 1'b0; halt_ID = 1'b0; halt_MEM_WB = 1'b0;
   endtask

   // Check the control vector mid-cycle, then advance to just after the next edge.
   task automatic cyc(input string tag, input logic [8:0] exp);
      @(negedge CLK);
      chk(tag, 32'(ctl), 32'(exp));
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      nRST = 1'b0;
      #3;
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(stall_count), 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;
   endtask

   initial begin
      nRST = 1'b1;
      idle_inputs();
      #2;
      do_reset();

      // No hazards
      for (int i = 0; i < 5; i++) cyc("norm", C_NORM);
      chk("norm_count", 32'(stall_count), 32'd0);

      // Memory stall for three cycles, then the access completes
      dREN_EX_MEM = 1'b1;
      for (int i = 0; i < 3; i++) cyc("dstall", C_FROZEN);
      dhit = 1'b1;
      cyc("dstall_done", C_NORM);
      chk("dstall_count", 32'(stall_count), 32'd3);
      dREN_EX_MEM = 1'b0; dhit = 1'b0;

      // Load-use on rs, then the load has moved on
      dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd8; Rs_IF_ID = 5'd8;
      cyc("luse_rs", C_BUBBLE);
      chk("luse_count", 32'(stall_count), 32'd4);
      dREN_ID_EX = 1'b0;
      cyc("luse_clear", C_NORM);
      // Destination r0 never creates a hazard
      dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0;
      cyc("luse_r0", C_NORM);
      // Load-use on rt
      Rt_ID_EX = 5'd9; Rt_IF_ID = 5'd9; Rs_IF_ID = 5'd3;
      cyc("luse_rt", C_BUBBLE);
      dREN_ID_EX = 1'b0;
      // Fetch miss
      ihit = 1'b0;
      cyc("imiss", C_BUBBLE);
      chk("imiss_count", 32'(stall_count), 32'd6);

      // Branch beats a fetch miss and a load-use hazard
      dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd8; Rs_IF_ID = 5'd8; branch_taken_EX = 1'b1;
      cyc("branch_prio", C_BRANCH);
      chk("branch_count", 32'(stall_count), 32'd6);
      idle_inputs();

      // Jump
      jump_ID = 1'b1;
      cyc("jump", C_JUMP);
      jump_ID = 1'b0;

      // Memory stall beats branch
      dWEN_EX_MEM = 1'b1; branch_taken_EX = 1'b1;
      cyc("dstall_over_branch", C_FROZEN);
      chk("dsb_count", 32'(stall_count), 32'd7);
      idle_inputs();

      // Halt enters ID/EX, then drain
      halt_ID = 1'b1;
      cyc("halt_enter", C_NORM);
      halt_ID = 1'b0;
      cyc("drain1", C_DRAIN);
      jump_ID = 1'b1;
      cyc("drain_jump_ignored", C_DRAIN);
      jump_ID = 1'b0; ihit = 1'b0;
      cyc("drain_imiss_ignored", C_DRAIN);
      ihit = 1'b1;
      chk("drain_halted", 32'(halted), 32'd0);
      halt_MEM_WB = 1'b1;
      cyc("drain_last", C_DRAIN);
      chk("halted_set", 32'(halted), 32'd1);
      chk("drain_count", 32'(stall_count), 32'd11);
      halt_MEM_WB = 1'b0; branch_taken_EX = 1'b1;
      cyc("halted_frozen", C_FROZEN);
      cyc("halted_frozen2", C_FROZEN);
      chk("halted_count", 32'(stall_count), 32'd11);
      chk("halted_stays", 32'(halted), 32'd1);

      // Reset out of HALTED; wrong-path halt cancelled by branch
      do_reset();
      halt_ID = 1'b1;
      cyc("halt2_enter", C_NORM);
      halt_ID = 1'b0;
      cyc("drain2", C_DRAIN);
      branch_taken_EX = 1'b1;
      cyc("drain_branch", C_BRANCH);
      branch_taken_EX = 1'b0;
      cyc("resume_run", C_NORM);
      chk("resume_count", 32'(stall_count), 32'd1);
      chk("resume_halted", 32'(halted), 32'd0);

      // halt_MEM_WB held off by a memory stall
      do_reset();
      dREN_EX_MEM = 1'b1; halt_MEM_WB = 1'b1;
      cyc("halt_dstall1", C_FROZEN);
      chk("halt_dstall_h1", 32'(halted), 32'd0);
      cyc("halt_dstall2", C_FROZEN);
      chk("halt_dstall_h2", 32'(halted), 32'd0);
      dhit = 1'b1;
      cyc("halt_dhit", C_NORM);
      chk("halt_after_dhit", 32'(halted), 32'd1);
      chk("halt_dstall_count", 32'(stall_count), 32'd2);

      // Counter saturation, then asynchronous reset mid-stall
      do_reset();
      ihit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK);
      end
      #1;
      chk("sat_count", 32'(stall_count), 32'd15);
      #2;
      nRST = 1'b0;
      #1;
      chk("async_rst_count", 32'(stall_count), 32'd0);
      chk("async_rst_halted", 32'(halted), 32'd0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It covers memory stalls, load-use hazards, branch/jump redirects and the halt drain sequence. It also keeps a stall-cycle performance counter.

Parameters:
REG_W, 5, register index width (regbits_t)
CNT_W, 32, stall counter width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dREN_EX_MEM  in  1  load in MEM stage
dWEN_EX_MEM  in  1  store in MEM stage
dREN_ID_EX  in  1  load in EX stage
Rt_ID_EX  in  REG_W  load destination in EX
Rs_IF_ID  in  REG_W  source rs of instruction in ID
Rt_IF_ID  in  REG_W  source rt of instruction in ID
branch_taken_EX  in  1  branch resolved taken in EX
jump_ID  in  1  J/JAL/JR decoded in ID
halt_ID  in  1  HALT decoded in ID
halt_MEM_WB  in  1  HALT held in MEM/WB
pc_en  out  1  PC register write enable
enable_IF_ID, flush_IF_ID  out  1 each  IF/ID control
enable_ID_EX, flush_ID_EX  out  1 each  ID/EX control
enable_EX_MEM, flush_EX_MEM  out  1 each  EX/MEM control
enable_MEM_WB, flush_MEM_WB  out  1 each  MEM/WB control
halted  out  1  CPU halted (registered)
stall_count  out  CNT_W  cycles with pc_en=0 while not HALTED

Behaviour:
- One clock CLK; reset nRST is asynchronous, active-low. Reset: state=RUN, halted=0, stall_count=0.
- State register: RUN, DRAIN, HALTED. halted=1 iff state==HALTED.
- All enable, flush and pc_en outputs are combinational from state and inputs.
- A flush overrides an enable at the pipeline register.
- Derived terms:
  - dstall = (dREN_EX_MEM|dWEN_EX_MEM) & !dhit
  - luse = dREN_ID_EX & (Rt_ID_EX!=0) & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID)
- Default: all enables 1, all flushes 0, pc_en=1.
- RUN/DRAIN priority, first match wins:
  - P1 dstall: all enables 0, all flushes 0, pc_en 0. Whole pipe frozen; state held (including any pending HALTED entry).
  - P2 branch_taken_EX: pc_en 1, flush_IF_ID 1, flush_ID_EX 1. A fetch in progress is abandoned even if ihit=0. In DRAIN, next state RUN (the halt was wrong-path).
  - DRAIN only, if P1/P2 not matched: pc_en 0, flush_IF_ID 1. ihit, luse and jump_ID are ignored.
  - P3 luse: pc_en 0, enable_IF_ID 0, flush_ID_EX 1. Lasts exactly one bubble; clears as the load advances.
  - P4 !ihit: same outputs as P3.
  - P5 jump_ID: flush_IF_ID 1, pc_en 1.
  - P6 no hazard: defaults.
- RUN->DRAIN when halt_ID=1 and the cycle's effective ID/EX load captures it: enable_ID_EX=1, flush_ID_EX=0, no P1.
- RUN/DRAIN->HALTED when halt_MEM_WB=1 and !dstall. Takes precedence over a P2 transition.
- HALTED: all enables 0, all flushes 0, pc_en 0. Inputs ignored; exit only via nRST.
- stall_count increments on each cycle with pc_en=0 and state!=HALTED. It saturates at all-ones and never wraps.
- Reset mid-stall or mid-drain returns to RUN immediately (asynchronous); the counter clears.

Test Plan:
- Reset, then ihit=1 with no hazards for 5 cycles -> all enables 1, all flushes 0, pc_en=1, stall_count=0.
- dREN_EX_MEM=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles with all enables 0 and pc_en 0, then resume; stall_count=3.
- dREN_ID_EX=1, Rt_ID_EX=8, Rs_IF_ID=8, ihit=1 -> one cycle of pc_en 0, enable_IF_ID 0, flush_ID_EX 1. Same case with Rt_ID_EX=0 -> no stall.
- branch_taken_EX=1 together with ihit=0 and luse=1 -> pc_en 1, flush_IF_ID 1, flush_ID_EX 1 (P2 wins).
- halt_ID=1 -> DRAIN: pc_en 0, flush_IF_ID 1. Then halt_MEM_WB=1 three cycles later -> halted=1 next edge; all enables 0 thereafter.
- In DRAIN, assert branch_taken_EX -> state returns to RUN, fetch resumes with pc_en 1. Separately, with dstall and halt_MEM_WB both 1 -> halted stays 0 until dhit=1.
